i2s_master_tx: RTL and testbench
================================

Name: i2s_master_tx

Overview:
- I2S master transmitter for the codec DAC path. Runs entirely on the FPGA system clock.
- Divides FPGACLK down to generate BCLK and LRCLK.
- Accepts stereo sample pairs through a valid/ready handshake into a one-deep holding register.
- Serializes each pair MSB-first onto SDATA in standard I2S framing, with a one-BCLK delay after each LRCLK edge. It is the transmit-side counterpart of the FIFO-fed sample reader, so synthesis output reaches the codec without a second clock domain.

Parameters:
- DATA_W, 16: sample width per channel; must satisfy DATA_W+1 <= SLOT_W.
- SLOT_W, 32: BCLK periods per channel slot; a frame is 2*SLOT_W BCLKs.
- CLK_DIV, 9: FPGACLK cycles per BCLK half-period; must be >= 2. Frame period = 4*SLOT_W*CLK_DIV cycles.
- CNT_W, 16: width of the underrun counter.

Ports:
- FPGACLK  in  1  system clock.
- Reset  in  1  synchronous active-high reset.
- en  in  1  run request.
- in_valid  in  1  sample pair valid.
- in_ready  out  1  holding register empty.
- sample_L  in  DATA_W  left sample, two's complement.
- sample_R  in  DATA_W  right sample, two's complement.
- BCLK  out  1  bit clock.
- LRCLK  out  1  word select; 0 = left, 1 = right.
- SDATA  out  1  serial data.
- frame_start  out  1  one-cycle pulse on each frame load.
- underrun  out  1  one-cycle pulse when a frame loads with no data.
- underrun_cnt  out  CNT_W  saturating count of underruns.

Behaviour:
- Reset: the synchronous, active-high Reset is sampled on the FPGACLK rising edge.
  - Registers return to reset values the next cycle, whether idle or mid-frame: BCLK=0, LRCLK=0, SDATA=0, frame_start=0, underrun=0, underrun_cnt=0.
  - Holding register is cleared, so in_ready=1 on the first cycle after Reset deasserts. Shift register and counters are cleared. FSM goes to IDLE.
- Handshake:
  - Transfer occurs on a cycle where in_valid & in_ready.
  - in_ready = ~hold_full (registered state, no combinational path from in_valid).
  - Data is captured into the holding register and hold_full sets on the next cycle.
  - The holding register accepts data in both IDLE and RUN.
- FSM states: IDLE, RUN.
  - IDLE: BCLK, LRCLK and SDATA are held at 0; divider and bit counter are held at 0.
  - IDLE -> RUN when en=1.
  - RUN -> IDLE only at the frame boundary (last BCLK falling edge of bit 2*SLOT_W-1) with en=0. Dropping en mid-frame always completes the current frame.
- Clock generation:
  - The divider counts 0..CLK_DIV-1 in RUN; BCLK toggles when the count is CLK_DIV-1.
  - A "fall" event is a 1->0 BCLK toggle. The bit counter b (0..2*SLOT_W-1, wraps) advances on each fall.
  - LRCLK and SDATA are registered and update in the same cycle BCLK falls, so they are stable when the codec samples on the BCLK rising edge.
- Framing:
  - LRCLK = 0 for b < SLOT_W, else 1.
  - Define k = b mod SLOT_W. SDATA carries sample bit [DATA_W-k] for 1 <= k <= DATA_W; otherwise SDATA=0.
- Frame load: occurs on the first RUN cycle and on every fall where b wraps to 0.
  - If hold_full: copy the holding register to the shift register and clear hold_full; in_ready rises the next cycle.
  - If the holding register is empty: load zeros, pulse underrun, and increment underrun_cnt, saturating at all-ones.
  - frame_start pulses on every load.
- Simultaneous events:
  - If a handshake coincides with a load while the holding register is empty, the accepted word goes to the holding register for the next frame. The current frame is still zeros and still counts as an underrun.
  - Reset takes priority over all events.

Decomposition:
- Package i2s_pkg: state enum (IDLE, RUN), default DATA_W/SLOT_W/CLK_DIV constants, and a parameter-legality check function.
- Sub-module i2s_clk_gen: divider, BCLK register, fall strobe, and bit counter, with start/stop inputs.
- The top level holds the FSM, holding register, shift register, and flags.

Test Plan (DATA_W=16, SLOT_W=32, CLK_DIV=2, 256 cycles/frame):
- Reset held 3 cycles, then released -> BCLK/LRCLK/SDATA/underrun = 0 and in_ready=1 on the first cycle after release; underrun_cnt=0.
- Single pair L=16'hA5C3, R=16'h8001, then en=1 -> frame_start pulses.
  - Left slot, sampled on BCLK rises: 0, 1010010111000011, then 15 zeros.
  - Right slot: LRCLK=1, then 0, 1000000000000001, then 15 zeros.
  - BCLK period is 4 cycles.
- en=1 with in_valid=0 for 3 frames -> SDATA constantly 0, underrun pulses 3 times, underrun_cnt=3.
- Back-to-back W0=(16'h1234,16'h5678) and W1=(16'h7FFF,16'h8000) with in_valid held -> W0 is accepted immediately; W1 is accepted the cycle after W0's frame load; in_ready stays low until frame 2 loads W1 and rises the next cycle; no underrun.
- en dropped at bit 10 of a frame -> the remaining 54 bits are output intact, then BCLK/LRCLK/SDATA stay 0 and the FSM is in IDLE.
- Reset asserted at bit 40 with a full holding register -> next cycle all outputs are at reset values and in_ready=1; the old word is never transmitted after restart.

Source files
------------

// File: rtl/i2s_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2s_pkg : shared state type, default sizes and parameter legality    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package i2s_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_e;

  localparam int I2S_DATA_W  = 16;
  localparam int I2S_SLOT_W  = 32;
  localparam int I2S_CLK_DIV = 9;
  localparam int I2S_CNT_W   = 16;

  // A sample plus the one-BCLK I2S delay must fit inside its slot.
  function automatic bit i2s_params_ok(input int data_w, input int slot_w, input int clk_div);
    return (data_w >= 1) && (data_w + 1 <= slot_w) && (clk_div >= 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_clk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2s_clk_gen : BCLK divider, falling-edge strobe and frame bit count  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module i2s_clk_gen #(
  parameter int SLOT_W  = 32,
  parameter int CLK_DIV = 9,
  parameter int BIT_W   = $clog2(2*SLOT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_run,
  output logic             o_bclk,
  output logic             o_fall,
  output logic             o_last_bit,
  output logic [BIT_W-1:0] o_bit_cnt
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             w_div_end;

  always_comb begin
    w_div_end  = (div_q == DIV_W'(CLK_DIV - 1));
    o_fall     = i_run && w_div_end && bclk_q;
    o_last_bit = (bit_q == BIT_W'(2*SLOT_W - 1));
    div_d      = div_q;
    bclk_d     = bclk_q;
    bit_d      = bit_q;
    if (!i_run) begin
      div_d  = '0;
      bclk_d = 1'b0;
      bit_d  = '0;
    end else begin
      div_d = w_div_end ? '0 : div_q + 1'b1;
      if (w_div_end) bclk_d = ~bclk_q;
      if (o_fall)    bit_d  = o_last_bit ? '0 : bit_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
      bit_q  <= '0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
      bit_q  <= bit_d;
    end
  end

  assign o_bclk    = bclk_q;
  assign o_bit_cnt = bit_q;

endmodule
`default_nettype wire

// File: rtl/i2s_master_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2s_master_tx : I2S master transmitter with one-deep sample holding  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module i2s_master_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W  = I2S_DATA_W,
  parameter int SLOT_W  = I2S_SLOT_W,
  parameter int CLK_DIV = I2S_CLK_DIV,
  parameter int CNT_W   = I2S_CNT_W
) (
  input  logic              FPGACLK,
  input  logic              Reset,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] sample_L,
  input  logic [DATA_W-1:0] sample_R,
  output logic              BCLK,
  output logic              LRCLK,
  output logic              SDATA,
  output logic              frame_start,
  output logic              underrun,
  output logic [CNT_W-1:0]  underrun_cnt
);

  localparam int BIT_W = $clog2(2*SLOT_W);
  localparam int FRM_W = 2*DATA_W;

  if (!i2s_params_ok(DATA_W, SLOT_W, CLK_DIV)) begin : g_param_check
    $error("i2s_master_tx: illegal DATA_W/SLOT_W/CLK_DIV combination");
  end

  i2s_state_e       state_q, state_d;
  logic [FRM_W-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [FRM_W-1:0] shift_q, shift_d;
  logic             lrclk_q, lrclk_d;
  logic             sdata_q, sdata_d;
  logic             frame_start_q, frame_start_d;
  logic             underrun_q, underrun_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             w_run, w_bclk, w_fall, w_last_bit, w_accept, w_load;
  logic [BIT_W-1:0] w_bit_cnt, w_next_bit, w_k;

  assign w_run = (state_q == RUN);

  i2s_clk_gen #(
    .SLOT_W  (SLOT_W),
    .CLK_DIV (CLK_DIV),
    .BIT_W   (BIT_W)
  ) u_clk_gen (
    .clk        (FPGACLK),
    .rst        (Reset),
    .i_run      (w_run),
    .o_bclk     (w_bclk),
    .o_fall     (w_fall),
    .o_last_bit (w_last_bit),
    .o_bit_cnt  (w_bit_cnt)
  );

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    shift_d       = shift_q;
    lrclk_d       = lrclk_q;
    sdata_d       = sdata_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    cnt_d         = cnt_q;
    w_load        = 1'b0;
    w_accept      = in_valid && !hold_full_q;
    w_next_bit    = w_last_bit ? '0 : w_bit_cnt + 1'b1;
    w_k           = (w_next_bit >= BIT_W'(SLOT_W)) ? w_next_bit - BIT_W'(SLOT_W) : w_next_bit;

    case (state_q)
      IDLE: begin
        lrclk_d = 1'b0;
        sdata_d = 1'b0;
        if (en) begin
          state_d = RUN;
          w_load  = 1'b1;
        end
      end
      RUN: begin
        if (w_fall) begin
          lrclk_d = (w_next_bit >= BIT_W'(SLOT_W));
          // Left word sits above right word, so one shift chain serves both slots.
          if (w_k >= BIT_W'(1) && w_k <= BIT_W'(DATA_W)) begin
            sdata_d = shift_q[FRM_W-1];
            shift_d = shift_q << 1;
          end else begin
            sdata_d = 1'b0;
          end
          if (w_last_bit) begin
            if (en) w_load  = 1'b1;
            else    state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_load) begin
      frame_start_d = 1'b1;
      if (hold_full_q) begin
        shift_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        shift_d    = '0;
        underrun_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
    end

    // Only possible while empty, so it never collides with a hold-to-shift copy.
    if (w_accept) begin
      hold_d      = {sample_L, sample_R};
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge FPGACLK) begin
    if (Reset) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      shift_q       <= '0;
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      shift_q       <= shift_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      cnt_q         <= cnt_d;
    end
  end

  assign in_ready     = !hold_full_q;
  assign BCLK         = w_bclk;
  assign LRCLK        = lrclk_q;
  assign SDATA        = sdata_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_master_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_i2s_master_tx : scoreboard bench for the I2S master transmitter   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_i2s_master_tx;

  localparam logic [63:0] EXP_LR = {32'h0000_0000, 32'hFFFF_FFFF};

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] sample_L = '0;
  logic [15:0] sample_R = '0;
  logic        in_ready, BCLK, LRCLK, SDATA, frame_start, underrun;
  logic [15:0] underrun_cnt;

  logic        s_ready, s_bclk, s_lrclk, s_sdata, s_fs, s_ur;
  logic [1:0]  s_cnt;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  i2s_master_tx #(.DATA_W(16), .SLOT_W(32), .CLK_DIV(2), .CNT_W(16)) dut (
    .FPGACLK(clk), .Reset(Reset), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .sample_L(sample_L), .sample_R(sample_R), .BCLK(BCLK), .LRCLK(LRCLK), .SDATA(SDATA),
    .frame_start(frame_start), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  // Narrow counter instance, never fed, to reach saturation quickly.
  i2s_master_tx #(.DATA_W(16), .SLOT_W(32), .CLK_DIV(2), .CNT_W(2)) dut_sat (
    .FPGACLK(clk), .Reset(Reset), .en(en), .in_valid(1'b0), .in_ready(s_ready),
    .sample_L(16'h0000), .sample_R(16'h0000), .BCLK(s_bclk), .LRCLK(s_lrclk), .SDATA(s_sdata),
    .frame_start(s_fs), .underrun(s_ur), .underrun_cnt(s_cnt)
  );

  function automatic logic [63:0] exp_sd(input logic [31:0] p);
    return {1'b0, p[31:16], 15'b0, 1'b0, p[15:0], 15'b0};
  endfunction

  task automatic drive_reset();
    Reset = 1'b1; en = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    sb_q.delete();
  endtask

  task automatic wait_fs(output bit to);
    int cyc = 0;
    to = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc > 1000) to = 1'b1;
    end while (frame_start !== 1'b1 && !to);
  endtask

  task automatic collect(input int n, input int drop_at, output logic [63:0] sd,
                         output logic [63:0] lr, output logic rdy_seen, output int period,
                         output bit to);
    int   rises = 0;
    int   cyc = 0;
    int   first = 0;
    logic prev;
    sd = '0; lr = '0; rdy_seen = 1'b0; period = 0; to = 1'b0; prev = BCLK;
    while (rises < n && !to) begin
      @(negedge clk);
      cyc++;
      rdy_seen = rdy_seen | in_ready;
      if (prev === 1'b0 && BCLK === 1'b1) begin
        sd = {sd[62:0], SDATA};
        lr = {lr[62:0], LRCLK};
        rises++;
        if (rises == 1) first = cyc;
        if (rises == 2) period = cyc - first;
        if (rises == drop_at) en = 1'b0;
      end
      prev = BCLK;
      if (cyc > 4000) to = 1'b1;
    end
  endtask

  task automatic test_reset();
    drive_reset();
    @(negedge clk);
    tests++;
    if ({BCLK, LRCLK, SDATA, underrun, frame_start} !== 5'b0) begin
      fails++; $display("FAIL reset_outputs: got %b expected 00000", {BCLK, LRCLK, SDATA, underrun, frame_start});
    end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    tests++;
    if (underrun_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %0d expected 0", underrun_cnt); end
  endtask

  task automatic test_single_pair();
    logic [63:0] sd, lr; logic rdy; int per; bit to; logic [31:0] exp;
    drive_reset();
    in_valid = 1'b1; sample_L = 16'hA5C3; sample_R = 16'h8001;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL single_ready_pre: got %b expected 1", in_ready); end
    sb_q.push_back({sample_L, sample_R});
    @(negedge clk);
    in_valid = 1'b0; en = 1'b1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL single_ready_full: got %b expected 0", in_ready); end
    wait_fs(to);
    tests++;
    if (to) begin fails++; $display("FAIL single_fs_timeout: got none expected frame_start"); end
    tests++;
    if (underrun !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL single_load_flags: got underrun=%b ready=%b expected 0,1", underrun, in_ready);
    end
    collect(64, 0, sd, lr, rdy, per, to);
    exp = sb_q.pop_front();
    tests++;
    if (to || sd !== exp_sd(exp)) begin fails++; $display("FAIL single_sdata: got %h expected %h", sd, exp_sd(exp)); end
    tests++;
    if (lr !== EXP_LR) begin fails++; $display("FAIL single_lrclk: got %h expected %h", lr, EXP_LR); end
    tests++;
    if (per !== 4) begin fails++; $display("FAIL single_bclk_period: got %0d expected 4", per); end
    en = 1'b0;
  endtask

  task automatic test_underrun();
    logic [63:0] sd, lr; logic rdy; int per; bit to; logic [31:0] exp;
    drive_reset();
    en = 1'b1;
    repeat (3) sb_q.push_back(32'h0);
    for (int i = 0; i < 3; i++) begin
      wait_fs(to);
      tests++;
      if (to || underrun !== 1'b1 || underrun_cnt !== 16'(i + 1)) begin
        fails++; $display("FAIL underrun_frame%0d: got ur=%b cnt=%0d expected 1,%0d", i, underrun, underrun_cnt, i + 1);
      end
      collect(64, 0, sd, lr, rdy, per, to);
      exp = sb_q.pop_front();
      tests++;
      if (to || sd !== exp_sd(exp)) begin fails++; $display("FAIL underrun_sdata%0d: got %h expected %h", i, sd, exp_sd(exp)); end
    end
    wait_fs(to);
    tests++;
    if (to || underrun_cnt !== 16'd4 || s_cnt !== 2'd3) begin
      fails++; $display("FAIL underrun_saturate: got cnt=%0d sat=%0d expected 4,3", underrun_cnt, s_cnt);
    end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] sd, lr; logic rdy; int per; bit to; logic [31:0] exp;
    drive_reset();
    in_valid = 1'b1; sample_L = 16'h1234; sample_R = 16'h5678;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_w0_accept: got %b expected 1", in_ready); end
    sb_q.push_back({sample_L, sample_R});
    @(negedge clk);
    sample_L = 16'h7FFF; sample_R = 16'h8000; en = 1'b1;
    wait_fs(to);
    tests++;
    if (to || in_ready !== 1'b1) begin fails++; $display("FAIL b2b_w1_accept: got ready=%b expected 1", in_ready); end
    sb_q.push_back({sample_L, sample_R});
    collect(64, 0, sd, lr, rdy, per, to);
    in_valid = 1'b0;
    exp = sb_q.pop_front();
    tests++;
    if (to || sd !== exp_sd(exp)) begin fails++; $display("FAIL b2b_frame1: got %h expected %h", sd, exp_sd(exp)); end
    tests++;
    if (rdy !== 1'b0) begin fails++; $display("FAIL b2b_ready_low: got seen=%b expected 0", rdy); end
    wait_fs(to);
    tests++;
    if (to || underrun !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_frame2_load: got ur=%b ready=%b expected 0,1", underrun, in_ready);
    end
    collect(64, 0, sd, lr, rdy, per, to);
    exp = sb_q.pop_front();
    tests++;
    if (to || sd !== exp_sd(exp)) begin fails++; $display("FAIL b2b_frame2: got %h expected %h", sd, exp_sd(exp)); end
    en = 1'b0;
  endtask

  task automatic test_en_drop();
    logic [63:0] sd, lr; logic rdy; int per; bit to; logic [31:0] exp; int bad;
    drive_reset();
    in_valid = 1'b1; sample_L = 16'hC001; sample_R = 16'h0FF0;
    sb_q.push_back({sample_L, sample_R});
    @(negedge clk);
    in_valid = 1'b0; en = 1'b1;
    wait_fs(to);
    collect(64, 11, sd, lr, rdy, per, to);
    exp = sb_q.pop_front();
    tests++;
    if (to || sd !== exp_sd(exp) || lr !== EXP_LR) begin
      fails++; $display("FAIL endrop_frame: got %h/%h expected %h/%h", sd, lr, exp_sd(exp), EXP_LR);
    end
    repeat (4) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ({BCLK, LRCLK, SDATA, frame_start} !== 4'b0) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL endrop_quiet: got %0d active cycles expected 0", bad); end
    tests++;
    if (dut.state_q !== i2s_pkg::IDLE) begin fails++; $display("FAIL endrop_state: got %0d expected IDLE", dut.state_q); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] sd, lr; logic rdy; int per; bit to; logic [31:0] exp;
    drive_reset();
    in_valid = 1'b1; sample_L = 16'hDEAD; sample_R = 16'hBEEF;
    sb_q.push_back({sample_L, sample_R});
    @(negedge clk);
    en = 1'b1; sample_L = 16'h5A5A; sample_R = 16'hC3C3;
    wait_fs(to);
    sb_q.push_back({sample_L, sample_R});
    @(negedge clk);
    in_valid = 1'b0;
    collect(40, 0, sd, lr, rdy, per, to);
    tests++;
    if (to || in_ready !== 1'b0) begin fails++; $display("FAIL midreset_hold_full: got ready=%b expected 0", in_ready); end
    Reset = 1'b1; en = 1'b0;
    @(negedge clk);
    sb_q.delete();
    tests++;
    if ({BCLK, LRCLK, SDATA, frame_start, underrun, in_ready} !== 6'b000001 || underrun_cnt !== 16'd0) begin
      fails++; $display("FAIL midreset_outputs: got %b cnt=%0d expected 000001 cnt=0",
                        {BCLK, LRCLK, SDATA, frame_start, underrun, in_ready}, underrun_cnt);
    end
    Reset = 1'b0; en = 1'b1;
    sb_q.push_back(32'h0);
    wait_fs(to);
    tests++;
    if (to || underrun !== 1'b1) begin fails++; $display("FAIL midreset_restart_ur: got %b expected 1", underrun); end
    collect(64, 0, sd, lr, rdy, per, to);
    exp = sb_q.pop_front();
    tests++;
    if (to || sd !== exp_sd(exp)) begin fails++; $display("FAIL midreset_restart_sdata: got %h expected %h", sd, exp_sd(exp)); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_underrun();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
